// File: rtl/rvcore_pkg.sv
// Shared definitions for the rvcore register file: index width, clear-FSM
// encoding and the register-index legality check.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package rvcore_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

  // x0 is hardwired to zero and indices at or above the implemented count
  // (RV32E) do not exist; neither may be written, read back or reserved.
  function automatic logic reg_legal(input logic [REG_IDX_W-1:0] idx, input int nreg);
    return (idx != '0) && (int'(idx) < nreg);
  endfunction

endpackage

// File: rtl/regfile_scb_if.sv
// Decode/issue + writeback bundle for regfile_scb.
// Ports: en, ready, rs/rdata/rbusy (NRP read ports), iss_valid/iss_rd/iss_ok
// (reservation handshake), we/rd/wdata (writeback). Latency/backpressure: n/a.
interface regfile_scb_if import rvcore_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NRP  = 2
);
  logic                     en;
  logic                     ready;
  logic [NRP*REG_IDX_W-1:0] rs;
  logic [NRP*XLEN-1:0]      rdata;
  logic [NRP-1:0]           rbusy;
  logic                     iss_valid;
  logic [REG_IDX_W-1:0]     iss_rd;
  logic                     iss_ok;
  logic                     we;
  logic [REG_IDX_W-1:0]     rd;
  logic [XLEN-1:0]          wdata;

  // Pipeline side
  modport master (
    output en, rs, iss_valid, iss_rd, we, rd, wdata,
    input  ready, rdata, rbusy, iss_ok
  );

  // Register file side
  modport slave (
    input  en, rs, iss_valid, iss_rd, we, rd, wdata,
    output ready, rdata, rbusy, iss_ok
  );
endinterface

// File: rtl/regfile_scb_board.sv
// Pending-bit scoreboard: one bit per register, set by an accepted issue and
// cleared by writeback. Latency: iss_ok is combinational, pend updates next edge.
// Backpressure: a rejected issue (iss_ok=0) is dropped; the issuer holds and stalls.
// Ports: clk/rst, act (ready & en), wr_en/wr_a (qualified writeback),
// iss_valid/iss_rd -> iss_ok, pend (registered pending vector).
module regfile_scb_board import rvcore_pkg::*; #(
  parameter int NREG = 32,
  localparam int IW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 act,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_a,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ok,
  output logic [NREG-1:0]      pend
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [IW-1:0]   iss_a;

  assign iss_a = iss_rd[IW-1:0];

  // Checked against the pre-write bit so a register still in flight can
  // never be reserved twice, even when its writeback lands this cycle.
  assign iss_ok = act && iss_valid && reg_legal(iss_rd, NREG) && !pend_q[iss_a];

  // Set is applied after clear: a new reservation outlives a same-cycle writeback.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[wr_a]  = 1'b0;
    if (iss_ok) pend_d[iss_a] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/regfile_scb.sv
// Register file with NRP combinational read ports, optional writeback bypass,
// pending scoreboard and a post-reset clear sequence (one entry per cycle).
// Latency: reads combinational, writes visible next cycle (same cycle with BYPASS).
// Backpressure: ready=0 during clear blocks everything; rejected issues are dropped.
// Ports: clk, rst (async, active-high), bus (regfile_scb_if.slave).
module regfile_scb import rvcore_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_scb_if.slave  bus
);

  localparam int            IW   = $clog2(NREG);
  localparam logic [IW-1:0] LAST = IW'(NREG - 1);

  logic [XLEN-1:0] mem [NREG];

  clr_state_t      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            clr_we;
  logic            ready;
  logic            wr_en;
  logic [IW-1:0]   wr_a;
  logic [NREG-1:0] pend;
  logic            iss_ok;

  // Clear FSM: x0 is never stored, so the sweep starts at entry 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= IW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    if (state_q == CLEAR) begin
      clr_we = 1'b1;
      idx_d  = idx_q + IW'(1);
      if (idx_q == LAST) state_d = RUN;
    end
  end

  // ready is the state register itself, so it is glitch-free.
  assign ready     = (state_q == RUN);
  assign bus.ready = ready;

  assign wr_en = ready && bus.en && bus.we && reg_legal(bus.rd, NREG);
  assign wr_a  = bus.rd[IW-1:0];

  // Storage has no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (clr_we)     mem[idx_q] <= '0;
    else if (wr_en) mem[wr_a]  <= bus.wdata;
  end

  regfile_scb_board #(.NREG(NREG)) u_board (
    .clk       (clk),
    .rst       (rst),
    .act       (ready && bus.en),
    .wr_en     (wr_en),
    .wr_a      (wr_a),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ok    (iss_ok),
    .pend      (pend)
  );

  assign bus.iss_ok = iss_ok;

  // Read ports. Illegal indices and the not-ready state read as zero and
  // never busy; forwarding implies legality because wr_en already checked rd.
  for (genvar g = 0; g < NRP; g++) begin : g_rp
    logic [REG_IDX_W-1:0] a;
    logic                 legal;
    logic                 fwd;

    assign a     = bus.rs[g*REG_IDX_W +: REG_IDX_W];
    assign legal = ready && reg_legal(a, NREG);
    assign fwd   = (BYPASS != 0) && wr_en && (bus.rd == a);

    assign bus.rdata[g*XLEN +: XLEN] = fwd   ? bus.wdata :
                                       legal ? mem[a[IW-1:0]] : '0;
    assign bus.rbusy[g]              = !fwd && legal && pend[a[IW-1:0]];
  end

endmodule

// File: tb/tb_regfile_scb.sv
module tb_regfile_scb;

  logic clk;
  logic rst;

  // Common stimulus, fanned out to three configurations
  logic        en, we, iv;
  logic [4:0]  rd, ir, r0, r1;
  logic [31:0] wd;

  int tests;
  int failed;

  regfile_scb_if #(.XLEN(32), .NRP(2)) ia ();  // NREG=32 BYPASS=1
  regfile_scb_if #(.XLEN(32), .NRP(2)) ib ();  // NREG=32 BYPASS=0
  regfile_scb_if #(.XLEN(32), .NRP(2)) ic ();  // NREG=16 BYPASS=1

  assign ia.en = en; assign ia.we = we; assign ia.rd = rd; assign ia.wdata = wd;
  assign ia.iss_valid = iv; assign ia.iss_rd = ir; assign ia.rs = {r1, r0};
  assign ib.en = en; assign ib.we = we; assign ib.rd = rd; assign ib.wdata = wd;
  assign ib.iss_valid = iv; assign ib.iss_rd = ir; assign ib.rs = {r1, r0};
  assign ic.en = en; assign ic.we = we; assign ic.rd = rd; assign ic.wdata = wd;
  assign ic.iss_valid = iv; assign ic.iss_rd = ir; assign ic.rs = {r1, r0};

  regfile_scb #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  regfile_scb #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  regfile_scb #(.XLEN(32), .NREG(16), .NRP(2), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        en, we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir, r0, r1;
    logic [31:0] e0, e1;   // dut_a rdata ports 0/1
    logic [1:0]  eb;       // dut_a rbusy {p1,p0}
    logic        eok;      // dut_a iss_ok
    logic [31:0] eb0;      // dut_b rdata port 0
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic w, input logic [4:0] d, input logic [31:0] dat,
                       input logic i, input logic [4:0] id, input logic [4:0] a0, input logic [4:0] a1);
    en = e; we = w; rd = d; wd = dat; iv = i; ir = id; r0 = a0; r1 = a1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a0, a1);
  endtask

  initial begin
    tests = 0;
    failed = 0;

    v[0]  = '{1'b1,1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 5'd5, 5'd0, 32'hDEADBEEF,32'h0,       2'b00,1'b0,32'h0};
    v[1]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd5, 5'd5, 32'hDEADBEEF,32'hDEADBEEF,2'b00,1'b0,32'hDEADBEEF};
    v[2]  = '{1'b1,1'b1,5'd0, 32'h1234,    1'b1,5'd0, 5'd0, 5'd0, 32'h0,       32'h0,       2'b00,1'b0,32'h0};
    v[3]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd0, 32'h0,       32'h0,       2'b00,1'b0,32'h0};
    v[4]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd7, 5'd7, 5'd5, 32'h0,       32'hDEADBEEF,2'b00,1'b1,32'h0};
    v[5]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd7, 5'd7, 5'd7, 32'h0,       32'h0,       2'b11,1'b0,32'h0};
    v[6]  = '{1'b1,1'b1,5'd7, 32'h55,      1'b0,5'd0, 5'd7, 5'd3, 32'h55,      32'h0,       2'b00,1'b0,32'h0};
    v[7]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd7, 5'd7, 32'h55,      32'h55,      2'b00,1'b0,32'h55};
    v[8]  = '{1'b1,1'b1,5'd9, 32'hAA,      1'b1,5'd9, 5'd9, 5'd7, 32'hAA,      32'h55,      2'b00,1'b1,32'h0};
    v[9]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd9, 5'd9, 32'hAA,      32'hAA,      2'b11,1'b0,32'hAA};
    v[10] = '{1'b1,1'b1,5'd9, 32'hBB,      1'b1,5'd9, 5'd9, 5'd1, 32'hBB,      32'h0,       2'b00,1'b0,32'hAA};
    v[11] = '{1'b0,1'b1,5'd3, 32'hCAFE,    1'b1,5'd4, 5'd3, 5'd9, 32'h0,       32'hBB,      2'b00,1'b0,32'h0};
    v[12] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd3, 5'd4, 32'h0,       32'h0,       2'b00,1'b0,32'h0};
    v[13] = '{1'b1,1'b1,5'd12,32'h12345678,1'b0,5'd0, 5'd1, 5'd12,32'h0,       32'h12345678,2'b00,1'b0,32'h0};
    v[14] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd12,5'd31,32'h12345678,32'h0,       2'b00,1'b0,32'h12345678};
    v[15] = '{1'b1,1'b1,5'd31,32'hF00DF00D,1'b1,5'd31,5'd31,5'd31,32'hF00DF00D,32'hF00DF00D,2'b00,1'b1,32'h0};
    v[16] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd31,5'd2, 32'hF00DF00D,32'h0,       2'b01,1'b0,32'hF00DF00D};

    // Reset with activity on the bus that must be ignored while not ready
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 5'd7, 5'd5, 5'd7);
    @(negedge clk);
    chk("rst_ready_a", {31'b0, ia.ready}, 32'd0);
    chk("rst_rdata_a", ia.rdata[31:0], 32'h0);
    chk("rst_rbusy_a", {30'b0, ia.rbusy}, 32'd0);
    chk("rst_issok_a", {31'b0, ia.iss_ok}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("clr1_ready_a", {31'b0, ia.ready}, 32'd0);
      chk("clr1_issok_a", {31'b0, ia.iss_ok}, 32'd0);
    end

    // Reset pulse mid-clear restarts the sweep
    rst = 1'b1;
    @(negedge clk);
    chk("pulse_ready_a", {31'b0, ia.ready}, 32'd0);
    chk("pulse_ready_c", {31'b0, ic.ready}, 32'd0);
    rst = 1'b0;
    idle(5'd0, 5'd0);

    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ready_a_e%0d", k), {31'b0, ia.ready}, {31'b0, k >= 31});
      chk($sformatf("ready_b_e%0d", k), {31'b0, ib.ready}, {31'b0, k >= 31});
      chk($sformatf("ready_c_e%0d", k), {31'b0, ic.ready}, {31'b0, k >= 15});
    end

    // Every entry reads zero after the clear; nothing was reserved during it
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'd7);
      @(negedge clk);
      chk($sformatf("clr_rd_a_x%0d", i), ia.rdata[31:0], 32'h0);
      chk($sformatf("clr_rd_c_x%0d", i), ic.rdata[31:0], 32'h0);
      chk("clr_busy7_a", {31'b0, ia.rbusy[1]}, 32'd0);
      @(posedge clk); #1;
    end

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(v[i].en, v[i].we, v[i].rd, v[i].wd, v[i].iv, v[i].ir, v[i].r0, v[i].r1);
      @(negedge clk);
      chk($sformatf("v%0d_rdata0_a", i), ia.rdata[31:0],  v[i].e0);
      chk($sformatf("v%0d_rdata1_a", i), ia.rdata[63:32], v[i].e1);
      chk($sformatf("v%0d_rbusy_a", i),  {30'b0, ia.rbusy}, {30'b0, v[i].eb});
      chk($sformatf("v%0d_issok_a", i),  {31'b0, ia.iss_ok}, {31'b0, v[i].eok});
      chk($sformatf("v%0d_rdata0_b", i), ib.rdata[31:0],  v[i].eb0);
      @(posedge clk); #1;
    end

    // NREG=16: index 20 does not exist and must not alias entry 4
    drive(1'b1, 1'b1, 5'd20, 32'h77777777, 1'b1, 5'd20, 5'd20, 5'd4);
    @(negedge clk);
    chk("c_rd20_rdata", ic.rdata[31:0], 32'h0);
    chk("c_rd20_rbusy", {30'b0, ic.rbusy}, 32'd0);
    chk("c_iss20_ok", {31'b0, ic.iss_ok}, 32'd0);
    chk("a_iss20_ok", {31'b0, ia.iss_ok}, 32'd1);
    chk("a_rd20_byp", ia.rdata[31:0], 32'h77777777);
    @(posedge clk); #1;
    idle(5'd20, 5'd4);
    @(negedge clk);
    chk("c_rs20_after", ic.rdata[31:0], 32'h0);
    chk("c_rs4_alias", ic.rdata[63:32], 32'h0);
    chk("c_rbusy_after", {30'b0, ic.rbusy}, 32'd0);
    chk("a_rbusy20", {31'b0, ia.rbusy[0]}, 32'd1);
    @(posedge clk); #1;

    // en=0 freezes writes and issues
    drive(1'b0, 1'b1, 5'd3, 32'h99, 1'b1, 5'd3, 5'd3, 5'd3);
    @(negedge clk);
    chk("c_en0_issok", {31'b0, ic.iss_ok}, 32'd0);
    chk("c_en0_rdata", ic.rdata[31:0], 32'h0);
    @(posedge clk); #1;
    idle(5'd3, 5'd15);
    @(negedge clk);
    chk("c_en0_after", ic.rdata[31:0], 32'h0);
    chk("c_en0_rbusy", {30'b0, ic.rbusy}, 32'd0);
    @(posedge clk); #1;

    // Highest legal index for NREG=16
    drive(1'b1, 1'b1, 5'd15, 32'h0F0F0F0F, 1'b1, 5'd15, 5'd15, 5'd5);
    @(negedge clk);
    chk("c_iss15_ok", {31'b0, ic.iss_ok}, 32'd1);
    chk("c_rd15_byp", ic.rdata[31:0], 32'h0F0F0F0F);
    chk("c_rd5", ic.rdata[63:32], 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 5'd15, 5'd14);
    @(negedge clk);
    chk("c_rs15_after", ic.rdata[31:0], 32'h0F0F0F0F);
    chk("c_rbusy15", {30'b0, ic.rbusy}, 32'd1);
    chk("c_reiss15_ok", {31'b0, ic.iss_ok}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
- Parametrised successor of the core's register file.
- Configurable register count (RV32I: 32, RV32E: 16) and N combinational read ports.
- Optional same-cycle write-to-read bypass.
- Per-register pending scoreboard with an issue handshake.
- After reset, a clear FSM zeroes the storage array one entry per cycle.
- Sits between decode/issue (reads, issue) and writeback (writes) in the rvcore pipeline.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; legal values 16 or 32.
- NRP, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = same-cycle writeback forwarding to read ports; 0 = none.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline enable; 0 freezes writes and scoreboard updates.
- ready  out  1  high once the clear sequence has finished.
- rs  in  NRP*5  read addresses; port i uses bits [5i+4:5i].
- rdata  out  NRP*XLEN  read data; port i uses [XLEN*(i+1)-1:XLEN*i].
- rbusy  out  NRP  pending bit of rs[i].
- iss_valid  in  1  issuer requests destination reservation.
- iss_rd  in  5  destination register to reserve.
- iss_ok  out  1  reservation accepted this cycle.
- we  in  1  writeback valid.
- rd  in  5  writeback destination.
- wdata  in  XLEN  writeback data.

Behaviour:
- Reset is asynchronous and active-high:
  - Clear index = 1, state = CLEAR.
  - ready = 0.
  - All pending bits = 0.
  - Storage array is not reset directly.
- State CLEAR:
  - Each clock, write 0 to entry[idx] and increment idx. This is independent of en.
  - After writing entry NREG-1, go to state RUN; ready rises on that edge.
  - Therefore ready = 1 exactly NREG-1 rising edges after rst deasserts.
- While ready = 0:
  - rdata = 0, rbusy = 0, iss_ok = 0.
  - we and iss_valid are ignored.
- Reset asserted mid-clear: sequence restarts from idx 1.
- Legal register index: 1..NREG-1.
  - Index 0 always reads 0, is never written, and is never pending.
  - Index >= NREG (NREG=16) reads 0 and has rbusy = 0; writes and issues to it are ignored, and iss_ok is forced to 0.
- Read (combinational):
  - rdata[i] = entry[rs[i]].
  - If BYPASS=1 and ready & en & we & rd==rs[i] & rd legal: rdata[i] = wdata and rbusy[i] = 0 that cycle.
  - Otherwise rbusy[i] = pending[rs[i]].
- Write:
  - If ready & en & we & rd legal: entry[rd] <= wdata and pending[rd] <= 0 on the next edge.
  - With BYPASS=0, the new value is visible to reads one cycle after the write.
- Issue:
  - iss_ok = ready & en & iss_valid & iss_rd legal & ~pending[iss_rd]. This prevents WAW on a single pending bit.
  - If iss_ok: pending[iss_rd] <= 1.
  - If iss_ok is low, the request is dropped; the issuer must hold it and stall.
- Simultaneous write and issue to the same rd:
  - pending[rd] clears in the same cycle (combinational view). iss_ok evaluates against the pre-write pending bit, so it is 0 when the bit was set.
  - If the issue is accepted (bit was clear), set wins: pending ends at 1, and the write still updates entry[rd].
- Write to a non-pending register: legal; the data is written and pending stays 0.
- en = 0:
  - No array write, no pending change, iss_ok = 0.
  - Reads remain valid; bypass is inactive.
- All outputs are combinational from state plus inputs, except ready, which is registered.

Decomposition:
- Shared package rvcore_pkg holds:
  - REG_IDX_W = 5.
  - Clear-FSM state encoding: CLEAR = 1'b0, RUN = 1'b1.
  - Helper function reg_legal(idx, NREG).
- Natural sub-module: regfile_scb_board. It holds the NREG-bit pending vector, the set/clear priority logic, and the iss_ok generation, and is parametrised by NREG.
- The top level holds the array, the clear FSM, the read muxes and the bypass.

Test Plan:
- Reset release with NREG=32 -> ready = 0 for 31 edges and 1 on edge 31. Every rs read afterwards returns 0. A reset pulse at edge 10 restarts the count: 31 more edges are needed.
- After ready, we=1, rd=5, wdata=0xDEADBEEF; rs[0]=5 in the same cycle -> BYPASS=1 gives rdata[0]=0xDEADBEEF; BYPASS=0 gives the old value, then 0xDEADBEEF on the next cycle.
- Write to x0 with wdata=0x1234, then read rs=0 -> 0. iss_valid with iss_rd=0 -> iss_ok = 0.
- Issue rd=7 -> iss_ok = 1, then rbusy for rs=7 is 1. A second issue of rd=7 -> iss_ok = 0. Writeback to rd=7 with 0x55 -> rbusy = 0 and reads return 0x55.
- Same cycle, pending[9]=0: issue rd=9 and write rd=9 with 0xAA -> entry = 0xAA and pending = 1 afterwards.
- NREG=16: write rd=20, then read rs=20 -> rdata = 0 and rbusy = 0; iss_rd=20 -> iss_ok = 0. With en=0, a write to rd=3 leaves entry 3 unchanged.
